// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Core clock-gate enable sequencer: idle hysteresis before gating, fixed-length
// wake sequence before release, and a saturating count of gated cycles.
module cv32e40p_clock_gate_ctrl #(
  parameter int IDLE_CNT_W  = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  idle_i,
  input  logic                  wake_req_i,
  input  logic                  force_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  output logic                  cg_en_o,
  output logic                  core_sleep_o,
  output logic                  wake_done_o,
  input  logic                  stat_clr_i,
  output logic [STAT_W-1:0]     gated_cnt_o,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_GATED     = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = 1;
  localparam logic [STAT_W-1:0]     STAT_ONE  = 1;
  localparam logic [3:0]            WAKE_ONE  = 4'd1;
  localparam logic [3:0]            WAKE_LOAD = 4'(WAKE_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [IDLE_CNT_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic [IDLE_CNT_W-1:0]   thr, thr_nxt;
  logic [3:0]              wake_cnt, wake_cnt_nxt;
  logic                    stay;

  assign stay      = idle_i & ~wake_req_i & ~force_en_i;
  assign fsm_state = state;

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    thr_nxt      = thr;
    wake_cnt_nxt = wake_cnt;
    case (state)
      ST_RUN: begin
        if (stay) begin
          state_nxt    = ST_IDLE_WAIT;
          idle_cnt_nxt = '0;
          thr_nxt      = idle_thresh_i;
        end
      end
      ST_IDLE_WAIT: begin
        if (!stay) begin
          state_nxt = ST_RUN;
        end else if (idle_cnt == thr) begin
          state_nxt = ST_GATED;
        end else begin
          idle_cnt_nxt = idle_cnt + IDLE_ONE;
        end
      end
      ST_GATED: begin
        // idle_i is deliberately not looked at here; only a wake source can leave.
        if (wake_req_i | force_en_i) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          wake_cnt_nxt = wake_cnt - WAKE_ONE;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs are decoded from next-state so the gate enable comes straight from a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_RUN;
      idle_cnt     <= '0;
      thr          <= '0;
      wake_cnt     <= '0;
      cg_en_o      <= 1'b1;
      core_sleep_o <= 1'b0;
      wake_done_o  <= 1'b0;
      gated_cnt_o  <= '0;
    end else begin
      state        <= state_nxt;
      idle_cnt     <= idle_cnt_nxt;
      thr          <= thr_nxt;
      wake_cnt     <= wake_cnt_nxt;
      cg_en_o      <= (state_nxt != ST_GATED);
      core_sleep_o <= (state_nxt == ST_GATED) || (state_nxt == ST_WAKE);
      wake_done_o  <= (state == ST_WAKE) && (state_nxt == ST_RUN);
      if (stat_clr_i) begin
        gated_cnt_o <= '0;
      end else if ((state == ST_GATED) && (gated_cnt_o != '1)) begin
        gated_cnt_o <= gated_cnt_o + STAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Bench for the clock-gate sequencer: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_cv32e40p_clock_gate_ctrl;

  localparam int WAKE = 2;

  logic        clk = 1'b0;
  logic        rst, idle, wake_req, force_en, stat_clr;
  logic [3:0]  idle_thresh;
  logic        cg_en_a, sleep_a, done_a, cg_en_b, sleep_b, done_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [1:0]  st_a, st_b;

  int checks = 0;
  int errors = 0;

  // model: gated flag, remaining wake cycles, length of the current stay run
  bit m_gated, m_done;
  int m_wake_left, m_streak, m_thr, m_cnt_a, m_cnt_b;

  always #5 clk = ~clk;

  cv32e40p_clock_gate_ctrl #(.IDLE_CNT_W(4), .WAKE_CYCLES(WAKE), .STAT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .idle_i(idle), .wake_req_i(wake_req), .force_en_i(force_en),
    .idle_thresh_i(idle_thresh), .cg_en_o(cg_en_a), .core_sleep_o(sleep_a),
    .wake_done_o(done_a), .stat_clr_i(stat_clr), .gated_cnt_o(cnt_a), .fsm_state(st_a)
  );

  cv32e40p_clock_gate_ctrl #(.IDLE_CNT_W(4), .WAKE_CYCLES(WAKE), .STAT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .idle_i(idle), .wake_req_i(wake_req), .force_en_i(force_en),
    .idle_thresh_i(idle_thresh), .cg_en_o(cg_en_b), .core_sleep_o(sleep_b),
    .wake_done_o(done_b), .stat_clr_i(stat_clr), .gated_cnt_o(cnt_b), .fsm_state(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit was_gated;
    was_gated = m_gated;
    if (rst) begin
      m_gated = 0; m_done = 0; m_wake_left = 0; m_streak = 0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      m_done = 0;
      if (m_wake_left > 0) begin
        m_wake_left--;
        if (m_wake_left == 0) m_done = 1;
      end else if (m_gated) begin
        if (wake_req || force_en) begin
          m_gated = 0; m_wake_left = WAKE; m_streak = 0;
        end
      end else if (idle && !wake_req && !force_en) begin
        m_streak++;
        if (m_streak == 1) m_thr = idle_thresh;
        if (m_streak == m_thr + 2) m_gated = 1;
      end else begin
        m_streak = 0;
      end
      if (stat_clr) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (was_gated) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("cg_en_a", 32'(cg_en_a), 32'(!m_gated));
    check("sleep_a", 32'(sleep_a), 32'(m_gated || m_wake_left > 0));
    check("done_a", 32'(done_a), 32'(m_done));
    check("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
    check("cg_en_b", 32'(cg_en_b), 32'(!m_gated));
    check("done_b", 32'(done_b), 32'(m_done));
    check("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
  endtask

  task automatic drive(input logic i, input logic w, input logic f, input logic c);
    idle = i; wake_req = w; force_en = f; stat_clr = c;
  endtask

  // steps until cg_en_a falls; n is the edge count, bounded
  task automatic wait_gated(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      n++;
      if (!cg_en_a) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int n, sl;

  initial begin
    rst = 1'b1; idle_thresh = 4'd3;
    drive(0, 0, 0, 0);
    do_reset();
    check("reset_cg_en", 32'(cg_en_a), 32'd1);
    check("reset_cnt", 32'(cnt_a), 32'd0);

    // gating latency with thr=3
    drive(1, 0, 0, 0);
    wait_gated(n);
    check("latency_thr3", n, 5);
    check("sleep_at_gate", 32'(sleep_a), 32'd1);

    // gated for 10 cycles, then one-cycle wake pulse
    repeat (9) step();
    drive(1, 1, 0, 0);
    step();
    drive(1, 0, 0, 0);
    check("gated_10", 32'(cnt_a), 32'd10);
    check("wake_cg_en", 32'(cg_en_a), 32'd1);
    sl = 1;
    for (int k = 0; k < 10 && sleep_a; k++) begin
      drive(0, 0, 0, 0);
      step();
      if (sleep_a) sl++;
      if (done_a) check("wake_len", sl, WAKE);
    end
    check("woke_sleep", 32'(sleep_a), 32'd0);

    // interrupted idle wait restarts the full count
    step();
    drive(1, 0, 0, 0);
    repeat (3) step();
    drive(0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0);
    wait_gated(n);
    check("latency_restart", n, 5);

    // clear while gated wins over increment, then counting resumes
    repeat (3) step();
    drive(1, 0, 0, 1);
    step();
    check("clr_zero", 32'(cnt_a), 32'd0);
    drive(1, 0, 0, 0);
    step();
    check("clr_resume", 32'(cnt_a), 32'd1);

    // saturation of the narrow counter
    repeat (20) step();
    check("sat_b", 32'(cnt_b), 32'd15);

    // force in GATED goes through WAKE
    drive(1, 0, 1, 0);
    step();
    check("force_wake_sleep", 32'(sleep_a), 32'd1);
    repeat (12) step();
    check("force_hold_run", 32'(cg_en_a), 32'd1);

    // thr=0 gives the minimum latency
    idle_thresh = 4'd0;
    drive(1, 0, 0, 0);
    wait_gated(n);
    check("latency_thr0", n, 2);

    // reset while GATED
    repeat (3) step();
    do_reset();
    check("rst_gated_sleep", 32'(sleep_a), 32'd0);

    // reset mid-WAKE
    wait_gated(n);
    drive(1, 1, 0, 0);
    step();
    drive(1, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wake_done", 32'(done_a), 32'd0);
    check("rst_wake_cg_en", 32'(cg_en_a), 32'd1);
    drive(0, 0, 0, 0);
    step();

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      idle        = ($urandom_range(0, 99) < 85);
      wake_req    = ($urandom_range(0, 99) < 6);
      force_en    = ($urandom_range(0, 99) < 3);
      stat_clr    = ($urandom_range(0, 99) < 2);
      rst         = ($urandom_range(0, 999) < 4);
      idle_thresh = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_clock_gate_ctrl.md
Name: cv32e40p_clock_gate_ctrl

Overview:
- Sequencer that drives the enable of the core clock gate cell.
- Decides when the core clock is cut: requires a programmable number of consecutive idle cycles first (hysteresis).
- Restores the clock on wake or override events through a fixed-length wake sequence.
- Runs on the free-running, ungated clock, sits beside the core clock gate, and counts gated cycles for power statistics.

Parameters:
- IDLE_CNT_W, 4: width of idle-threshold input and idle hysteresis counter.
- WAKE_CYCLES, 2: cycles clock is re-enabled before the core is released; legal range 1..15.
- STAT_W, 16: width of saturating gated-cycle counter.

Ports:
- clk_i  input  1  free-running (ungated) clock.
- rst_i  input  1  synchronous reset, active-high.
- idle_i  input  1  core reports pipeline drained and idle.
- wake_req_i  input  1  pending interrupt/debug request; level.
- force_en_i  input  1  test/debug override; clock must run.
- idle_thresh_i  input  IDLE_CNT_W  extra idle cycles required before gating.
- cg_en_o  output  1  enable to clock gate cell; registered.
- core_sleep_o  output  1  core is gated or waking; registered.
- wake_done_o  output  1  one-cycle pulse when core is released to RUN.
- stat_clr_i  input  1  clears gated-cycle counter.
- gated_cnt_o  output  STAT_W  saturating count of cycles spent in GATED.

Behaviour:
- Interface (decided): one clock, clk_i; reset rst_i is synchronous and active-high. All state changes occur on the rising edge of clk_i.
- Reset values: state=RUN, cg_en_o=1, core_sleep_o=0, wake_done_o=0, gated_cnt_o=0, idle counter=0, wake counter=0.
- Reset applies mid-operation from any state, including GATED, and forces the clock enabled on the next edge.
- Outputs are registered and decoded from next-state: RUN/IDLE_WAIT give cg_en_o=1; GATED gives cg_en_o=0; WAKE gives cg_en_o=1. core_sleep_o=1 only in GATED and WAKE.
- Define stay = idle_i & ~wake_req_i & ~force_en_i.
- RUN:
  - If stay: go to IDLE_WAIT, clear idle counter, latch idle_thresh_i into thr.
  - Otherwise remain in RUN.
- IDLE_WAIT:
  - If ~stay: go to RUN; counter is discarded.
  - Else if cnt==thr: go to GATED.
  - Else cnt+=1.
  - thr is latched on entry; later changes to idle_thresh_i have no effect until the next entry.
  - Counter never wraps: cnt<=thr<=2^IDLE_CNT_W-1.
  - Gating latency: cg_en_o falls thr+2 cycles after the first cycle stay is sampled high. Example: thr=0 → falls after 2 edges.
- GATED:
  - idle_i is ignored.
  - If wake_req_i | force_en_i: go to WAKE, load wake counter with WAKE_CYCLES-1.
  - gated_cnt_o increments by 1 for each cycle the registered state is GATED; saturates at all-ones.
- WAKE:
  - Inputs are ignored (wake sequence is non-abortable).
  - If wake counter==0: go to RUN and assert wake_done_o for 1 cycle, coincident with core_sleep_o falling.
  - Else decrement the counter.
  - cg_en_o is high for exactly WAKE_CYCLES cycles with core_sleep_o=1 before release.
- Priority: wake_req_i and force_en_i both block entry to and progress through IDLE_WAIT, irrespective of idle_i.
- force_en_i never bypasses WAKE: GATED always goes through WAKE to RUN.
- stat_clr_i:
  - Zeroes gated_cnt_o next cycle.
  - If asserted while GATED, the counter reads 0 after that edge and resumes counting on the following cycle (clear wins over increment).
- No combinational path from any input to cg_en_o; glitch-free enable to the gate cell.

Test Plan:
- Reset, then idle_i=1 steady with idle_thresh_i=3 → cg_en_o falls exactly 5 cycles after idle_i first sampled; core_sleep_o rises the same cycle.
- In IDLE_WAIT at cnt=2 (thr=3), drop idle_i for 1 cycle → return to RUN, cg_en_o never drops; reassert idle_i → full 5-cycle count restarts.
- From GATED, pulse wake_req_i for 1 cycle with WAKE_CYCLES=2 → cg_en_o=1 next edge; core_sleep_o stays 1 for 2 cycles; wake_done_o pulses once; RUN reached.
- force_en_i=1 while idle_i=1 → never leaves RUN. force_en_i asserted in GATED → passes through WAKE for WAKE_CYCLES cycles, then RUN.
- Gate for 10 cycles, then wake → gated_cnt_o=10. With STAT_W=4, gate for 20 cycles → gated_cnt_o=15. stat_clr_i while GATED → 0, then 1 the next cycle.
- Assert rst_i while GATED, and again mid-WAKE → cg_en_o=1, core_sleep_o=0, gated_cnt_o=0 after one edge; no wake_done_o pulse.
